// File: rtl/pipeline_hazard_ctrl.sv
// Front-end control for the rv32 core: fetch redirect on branches and traps,
// prioritised trap entry with per-source ack, CSR RAW stall and atomic CSR drain.
module pipeline_hazard_ctrl #(
  parameter int N_TRAP_SRC   = 4,
  parameter int N_CSR_STAGES = 2,
  parameter int ATOMIC_DRAIN = 3,
  localparam int IDX_W = (N_TRAP_SRC > 1) ? $clog2(N_TRAP_SRC) : 1,
  localparam int CNT_W = (ATOMIC_DRAIN > 1) ? $clog2(ATOMIC_DRAIN) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       branch,
  input  logic [31:0]                branch_addr,
  input  logic [N_TRAP_SRC-1:0]      trap_req,
  input  logic [32*N_TRAP_SRC-1:0]   trap_addr,
  output logic [N_TRAP_SRC-1:0]      trap_ack,
  input  logic                       csr_rd_en,
  input  logic [11:0]                decode_csr_addr,
  input  logic [N_CSR_STAGES-1:0]    csr_wr_en,
  input  logic [12*N_CSR_STAGES-1:0] csr_wr_addr,
  input  logic                       atomic_csr,
  input  logic                       bubble_decode,
  input  logic                       squash_decode,
  output logic                       next_pc_en,
  output logic [31:0]                next_pc,
  output logic                       bubble_fetch,
  output logic                       stall_decode,
  output logic                       trap_insert,
  output logic [IDX_W-1:0]           trap_idx,
  output logic                       atomic_csr_pending,
  output logic                       busy
);

  typedef enum logic [1:0] {RUN, ATOMIC, TRAP_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;

  logic             empty, branch_v, csr_rd_v, atomic_v;
  logic             csr_hit, insert, pending;
  logic [IDX_W-1:0] sel_idx;
  logic [31:0]      sel_addr;
  logic [N_TRAP_SRC-1:0] ack_raw;

  // An empty or squashed decode slot must not redirect, stall or start a drain.
  assign empty    = bubble_decode | squash_decode;
  assign branch_v = branch & ~empty;
  assign csr_rd_v = csr_rd_en & ~empty;
  assign atomic_v = atomic_csr & ~empty;

  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    for (int k = N_TRAP_SRC - 1; k >= 0; k--) begin
      if (trap_req[k]) begin
        sel_idx  = IDX_W'(k);
        sel_addr = trap_addr[32*k +: 32];
      end
    end
  end

  always_comb begin
    csr_hit = 1'b0;
    for (int k = 0; k < N_CSR_STAGES; k++) begin
      if (csr_wr_en[k] && (csr_wr_addr[12*k +: 12] == decode_csr_addr)) csr_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  // Arbitration happens only in RUN; an atomic op in decode wins over a trap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    insert  = 1'b0;
    pending = 1'b0;
    unique case (state_q)
      RUN: begin
        if (atomic_v) begin
          state_d = ATOMIC;
          cnt_d   = CNT_W'(ATOMIC_DRAIN - 1);
          pending = 1'b1;
        end else if (|trap_req) begin
          state_d = TRAP_WAIT;
          idx_d   = sel_idx;
          addr_d  = sel_addr;
        end
      end
      ATOMIC: begin
        pending = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      TRAP_WAIT: begin
        if (empty) begin
          insert  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ack_raw = '0;
    if (insert) ack_raw[idx_q] = 1'b1;
  end

  // Outputs are forced low while reset is held so nothing leaks mid-reset.
  assign trap_ack           = rst_n ? ack_raw : '0;
  assign trap_insert        = rst_n & insert;
  assign next_pc_en         = rst_n & (branch_v | insert);
  assign next_pc            = !rst_n ? 32'h0 : (branch_v ? branch_addr : addr_q);
  assign bubble_fetch       = rst_n & (branch_v | (state_q != RUN) | atomic_v |
                                       ((state_q == RUN) & (|trap_req)));
  assign stall_decode       = rst_n & csr_rd_v & csr_hit;
  assign trap_idx           = rst_n ? idx_q : '0;
  assign atomic_csr_pending = rst_n & pending;
  assign busy               = rst_n & (state_q != RUN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int NT = 4;
  localparam int NC = 2;
  localparam int DRAIN = 3;

  logic          clk;
  logic          rst_n;
  logic          branch;
  logic [31:0]   branch_addr;
  logic [NT-1:0] trap_req;
  logic [32*NT-1:0] trap_addr;
  logic [NT-1:0] trap_ack;
  logic          csr_rd_en;
  logic [11:0]   decode_csr_addr;
  logic [NC-1:0] csr_wr_en;
  logic [12*NC-1:0] csr_wr_addr;
  logic          atomic_csr;
  logic          bubble_decode;
  logic          squash_decode;
  logic          next_pc_en;
  logic [31:0]   next_pc;
  logic          bubble_fetch;
  logic          stall_decode;
  logic          trap_insert;
  logic [1:0]    trap_idx;
  logic          atomic_csr_pending;
  logic          busy;

  pipeline_hazard_ctrl #(.N_TRAP_SRC(NT), .N_CSR_STAGES(NC), .ATOMIC_DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .branch_addr(branch_addr),
    .trap_req(trap_req), .trap_addr(trap_addr), .trap_ack(trap_ack),
    .csr_rd_en(csr_rd_en), .decode_csr_addr(decode_csr_addr),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .atomic_csr(atomic_csr),
    .bubble_decode(bubble_decode), .squash_decode(squash_decode),
    .next_pc_en(next_pc_en), .next_pc(next_pc), .bubble_fetch(bubble_fetch),
    .stall_decode(stall_decode), .trap_insert(trap_insert), .trap_idx(trap_idx),
    .atomic_csr_pending(atomic_csr_pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycles of drain still owed, whether a trap is waiting, and what was latched.
  int          m_drain = 0;
  bit          m_wait  = 1'b0;
  int          m_idx   = 0;
  logic [31:0] m_addr  = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int lowestReq(input logic [NT-1:0] req);
    int r = 0;
    for (int k = NT - 1; k >= 0; k--) if (req[k]) r = k;
    return r;
  endfunction

  function automatic logic [11:0] csrPick();
    return 12'h300 + 12'($urandom_range(0, 2));
  endfunction

  always @(posedge clk) begin : model
    if (!rst_n) begin
      m_drain <= 0;
      m_wait  <= 1'b0;
      m_idx   <= 0;
      m_addr  <= '0;
    end else if (m_drain > 0) begin
      m_drain <= m_drain - 1;
    end else if (m_wait) begin
      if (bubble_decode || squash_decode) m_wait <= 1'b0;
    end else if (atomic_csr && !(bubble_decode || squash_decode)) begin
      m_drain <= DRAIN;
    end else if (trap_req != '0) begin
      m_wait  <= 1'b1;
      m_idx   <= lowestReq(trap_req);
      m_addr  <= trap_addr[32*lowestReq(trap_req) +: 32];
    end
  end

  always @(negedge clk) begin : compare
    bit e_empty, e_br, e_at, e_hit, e_busy, e_ins;
    logic [NT-1:0] e_ack;
    e_empty = bubble_decode | squash_decode;
    e_br    = branch & !e_empty;
    e_at    = atomic_csr & !e_empty;
    e_hit   = 1'b0;
    for (int k = 0; k < NC; k++)
      if (csr_wr_en[k] && csr_wr_addr[12*k +: 12] == decode_csr_addr) e_hit = 1'b1;
    e_busy  = (m_drain > 0) || m_wait;
    e_ins   = m_wait && e_empty;
    e_ack   = e_ins ? (4'b0001 << m_idx) : 4'b0000;
    if (!rst_n) begin
      checkOutput("rst_outputs", 32'({trap_ack, next_pc_en, bubble_fetch, stall_decode,
                  trap_insert, trap_idx, atomic_csr_pending, busy}), 32'h0);
      checkOutput("rst_next_pc", next_pc, 32'h0);
    end else begin
      checkOutput("stall_decode", 32'(stall_decode), 32'(csr_rd_en & !e_empty & e_hit));
      checkOutput("trap_insert", 32'(trap_insert), 32'(e_ins));
      checkOutput("trap_ack", 32'(trap_ack), 32'(e_ack));
      checkOutput("next_pc_en", 32'(next_pc_en), 32'(e_br | e_ins));
      checkOutput("next_pc", next_pc, e_br ? branch_addr : m_addr);
      checkOutput("bubble_fetch", 32'(bubble_fetch),
                  32'(e_br | e_busy | e_at | (!e_busy && trap_req != '0)));
      checkOutput("pending", 32'(atomic_csr_pending), 32'((m_drain > 0) || (!e_busy && e_at)));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("trap_idx", 32'(trap_idx), 32'(m_idx));
    end
  end

  initial begin
    rst_n = 1'b0; branch = 1'b0; branch_addr = '0; trap_req = '0; trap_addr = '0;
    csr_rd_en = 1'b0; decode_csr_addr = '0; csr_wr_en = '0; csr_wr_addr = '0;
    atomic_csr = 1'b0; bubble_decode = 1'b0; squash_decode = 1'b0;
    applyStimulus(2);

    // CSR read-after-write stall and its filtering
    rst_n = 1'b1; csr_rd_en = 1'b1; decode_csr_addr = 12'h300;
    csr_wr_en = 2'b10; csr_wr_addr = {12'h300, 12'h000};
    @(negedge clk); checkOutput("lit_stall_hit", 32'(stall_decode), 32'd1);
    checkOutput("lit_reset_busy", 32'(busy), 32'd0);
    applyStimulus(1); decode_csr_addr = 12'h305;
    @(negedge clk); checkOutput("lit_stall_miss", 32'(stall_decode), 32'd0);
    applyStimulus(1); decode_csr_addr = 12'h300; bubble_decode = 1'b1;
    @(negedge clk); checkOutput("lit_stall_bubble", 32'(stall_decode), 32'd0);

    // Trap priority: sources 1 and 3 raised, source 1 wins
    applyStimulus(1); csr_rd_en = 1'b0; csr_wr_en = '0; bubble_decode = 1'b0;
    trap_addr[32*1 +: 32] = 32'h100; trap_addr[32*3 +: 32] = 32'h200; trap_req = 4'b1010;
    @(negedge clk); checkOutput("lit_trap_bf0", 32'(bubble_fetch), 32'd1);
    applyStimulus(1);
    @(negedge clk); checkOutput("lit_trap_wait_ins", 32'(trap_insert), 32'd0);
    checkOutput("lit_trap_wait_bf", 32'(bubble_fetch), 32'd1);
    applyStimulus(1); bubble_decode = 1'b1;
    @(negedge clk); checkOutput("lit_trap_ins", 32'(trap_insert), 32'd1);
    checkOutput("lit_trap_pc", next_pc, 32'h100);
    checkOutput("lit_trap_ack", 32'(trap_ack), 32'b0010);
    checkOutput("lit_trap_idx", 32'(trap_idx), 32'd1);
    applyStimulus(1); trap_req = '0;
    @(negedge clk); checkOutput("lit_trap_ack_off", 32'(trap_ack), 32'd0);
    checkOutput("lit_trap_ins_off", 32'(trap_insert), 32'd0);

    // Atomic drain: detect cycle plus DRAIN held cycles, trap deferred
    applyStimulus(1); bubble_decode = 1'b0; atomic_csr = 1'b1;
    @(negedge clk); checkOutput("lit_atomic_detect", 32'(atomic_csr_pending), 32'd1);
    applyStimulus(1); atomic_csr = 1'b0; trap_addr[32*2 +: 32] = 32'h300; trap_req = 4'b0100;
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk); checkOutput("lit_atomic_hold", 32'(atomic_csr_pending), 32'd1);
      checkOutput("lit_atomic_noins", 32'(trap_insert), 32'd0);
      applyStimulus(1);
    end
    @(negedge clk); checkOutput("lit_atomic_done", 32'(atomic_csr_pending), 32'd0);
    checkOutput("lit_atomic_run", 32'(busy), 32'd0);
    applyStimulus(1); bubble_decode = 1'b1;
    @(negedge clk); checkOutput("lit_deferred_idx", 32'(trap_idx), 32'd2);
    checkOutput("lit_deferred_pc", next_pc, 32'h300);
    applyStimulus(1); trap_req = '0; bubble_decode = 1'b0;

    // Squashed decode filters atomic and branch
    atomic_csr = 1'b1; branch = 1'b1; squash_decode = 1'b1; branch_addr = 32'h1234;
    @(negedge clk); checkOutput("lit_squash_pend", 32'(atomic_csr_pending), 32'd0);
    checkOutput("lit_squash_npc", 32'(next_pc_en), 32'd0);
    applyStimulus(1); atomic_csr = 1'b0; branch = 1'b0; squash_decode = 1'b0;
    @(negedge clk); checkOutput("lit_squash_run", 32'(busy), 32'd0);

    // Branch while a trap waits, then the trap on the next empty slot
    applyStimulus(1); trap_addr[31:0] = 32'h80; trap_req = 4'b0001;
    applyStimulus(1); branch = 1'b1; branch_addr = 32'h44;
    @(negedge clk); checkOutput("lit_brw_pc", next_pc, 32'h44);
    checkOutput("lit_brw_ack", 32'(trap_ack), 32'd0);
    checkOutput("lit_brw_busy", 32'(busy), 32'd1);
    applyStimulus(1); branch = 1'b0; bubble_decode = 1'b1;
    @(negedge clk); checkOutput("lit_brw_trap_pc", next_pc, 32'h80);
    checkOutput("lit_brw_trap_ack", 32'(trap_ack), 32'b0001);
    applyStimulus(1); trap_req = '0; bubble_decode = 1'b0;

    // Reset while a trap waits drops it
    trap_req = 4'b0100;
    applyStimulus(1);
    @(negedge clk); checkOutput("lit_rmid_busy", 32'(busy), 32'd1);
    applyStimulus(1); rst_n = 1'b0; bubble_decode = 1'b1;
    @(negedge clk); checkOutput("lit_rmid_ack", 32'(trap_ack), 32'd0);
    applyStimulus(1); rst_n = 1'b1; trap_req = '0; bubble_decode = 1'b0;
    @(negedge clk); checkOutput("lit_rmid_idx", 32'(trap_idx), 32'd0);
    checkOutput("lit_rmid_run", 32'(busy), 32'd0);
    checkOutput("lit_rmid_pc", next_pc, 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1);
      rst_n         = ($urandom_range(0, 199) != 0);
      branch        = ($urandom_range(0, 3) == 0);
      branch_addr   = $urandom;
      bubble_decode = ($urandom_range(0, 2) == 0);
      squash_decode = ($urandom_range(0, 5) == 0);
      atomic_csr    = ($urandom_range(0, 9) == 0);
      csr_rd_en     = $urandom_range(0, 1) == 1;
      decode_csr_addr = csrPick();
      csr_wr_en     = 2'($urandom);
      csr_wr_addr   = {csrPick(), csrPick()};
      if ($urandom_range(0, 3) == 0)
        trap_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 15) == 0)
        for (int k = 0; k < NT; k++) trap_addr[32*k +: 32] = $urandom;
    end
    applyStimulus(1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
